axi_aw_arb3: RTL and testbench

AXI_AW_ARB3 -- requirements
Module: axi_aw_arb3

---
 rtl/axi_aw_arb3.sv | 173 +++++++++++++++++
 tb/tb_axi_aw_arb3.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_aw_arb3.sv
// Three-port AXI write-address arbiter with fixed, round-robin and weighted modes.
// One registered output slot; m_awid carries the source port index in its top two bits.
module axi_aw_arb3 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                arb_en,
  input  logic [1:0]          arb_mode,
  input  logic [15:0]         weight_setting0,
  input  logic [15:0]         weight_setting1,
  input  logic [15:0]         weight_setting2,
  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic [ID_W-1:0]     s0_awid,
  input  logic [LEN_W-1:0]    s0_awlen,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic [ID_W-1:0]     s1_awid,
  input  logic [LEN_W-1:0]    s1_awlen,
  input  logic                s2_awvalid,
  output logic                s2_awready,
  input  logic [ADDR_W-1:0]   s2_awaddr,
  input  logic [ID_W-1:0]     s2_awid,
  input  logic [LEN_W-1:0]    s2_awlen,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [ID_W+1:0]     m_awid,
  output logic [LEN_W-1:0]    m_awlen
);
  localparam int unsigned CNT_W = 17;
  localparam int unsigned MID_W = ID_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0] LAST_RST = 2'd2;

  logic [1:0]        last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m_awvalid_q, m_awvalid_d;
  logic [ADDR_W-1:0] m_awaddr_q, m_awaddr_d;
  logic [MID_W-1:0]  m_awid_q, m_awid_d;
  logic [LEN_W-1:0]  m_awlen_q, m_awlen_d;

  logic [2:0]  valid, rr_grant, grant, ready, last_oh;
  logic [15:0] last_weight;
  logic        last_valid, quota_ok, slot_free;
  logic [1:0]  acc_port;

  assign valid     = {s2_awvalid, s1_awvalid, s0_awvalid};
  assign slot_free = ~m_awvalid_q | m_awready;

  // Rotation order after the last accepted port, plus that port's quota view.
  always_comb begin
    rr_grant    = 3'b000;
    last_oh     = 3'b100;
    last_weight = weight_setting2;
    case (last_q)
      2'd0: begin
        last_oh     = 3'b001;
        last_weight = weight_setting0;
        if (valid[1])      rr_grant = 3'b010;
        else if (valid[2]) rr_grant = 3'b100;
        else if (valid[0]) rr_grant = 3'b001;
      end
      2'd1: begin
        last_oh     = 3'b010;
        last_weight = weight_setting1;
        if (valid[2])      rr_grant = 3'b100;
        else if (valid[0]) rr_grant = 3'b001;
        else if (valid[1]) rr_grant = 3'b010;
      end
      default: begin
        if (valid[0])      rr_grant = 3'b001;
        else if (valid[1]) rr_grant = 3'b010;
        else if (valid[2]) rr_grant = 3'b100;
      end
    endcase
  end

  // cnt==0 means nothing accepted since reset, so the quota never holds a port then.
  assign last_valid = |(valid & last_oh);
  assign quota_ok   = (cnt_q != '0) && (cnt_q <= {1'b0, last_weight});

  always_comb begin
    grant = 3'b000;
    if (!arb_en) begin
      grant = {2'b00, valid[0]};
    end else begin
      case (arb_mode)
        2'd0: begin
          if (valid[0])      grant = 3'b001;
          else if (valid[1]) grant = 3'b010;
          else if (valid[2]) grant = 3'b100;
        end
        2'd2:    grant = (last_valid && quota_ok) ? last_oh : rr_grant;
        default: grant = rr_grant;
      endcase
    end
  end

  assign ready      = (slot_free && !areset) ? grant : 3'b000;
  assign s0_awready = ready[0];
  assign s1_awready = ready[1];
  assign s2_awready = ready[2];

  // Slot load/drain and last/cnt bookkeeping.
  always_comb begin
    last_d      = last_q;
    cnt_d       = cnt_q;
    m_awvalid_d = m_awvalid_q;
    m_awaddr_d  = m_awaddr_q;
    m_awid_d    = m_awid_q;
    m_awlen_d   = m_awlen_q;
    acc_port    = 2'd0;
    if (m_awready) m_awvalid_d = 1'b0;
    if (|ready) begin
      m_awvalid_d = 1'b1;
      case (ready)
        3'b010: begin
          acc_port   = 2'd1;
          m_awaddr_d = s1_awaddr;
          m_awid_d   = {2'd1, s1_awid};
          m_awlen_d  = s1_awlen;
        end
        3'b100: begin
          acc_port   = 2'd2;
          m_awaddr_d = s2_awaddr;
          m_awid_d   = {2'd2, s2_awid};
          m_awlen_d  = s2_awlen;
        end
        default: begin
          acc_port   = 2'd0;
          m_awaddr_d = s0_awaddr;
          m_awid_d   = {2'd0, s0_awid};
          m_awlen_d  = s0_awlen;
        end
      endcase
      if (acc_port == last_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        last_d = acc_port;
        cnt_d  = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      last_q      <= LAST_RST;
      cnt_q       <= '0;
      m_awvalid_q <= 1'b0;
      m_awaddr_q  <= '0;
      m_awid_q    <= '0;
      m_awlen_q   <= '0;
    end else begin
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      m_awvalid_q <= m_awvalid_d;
      m_awaddr_q  <= m_awaddr_d;
      m_awid_q    <= m_awid_d;
      m_awlen_q   <= m_awlen_d;
    end
  end

  assign m_awvalid = m_awvalid_q;
  assign m_awaddr  = m_awaddr_q;
  assign m_awid    = m_awid_q;
  assign m_awlen   = m_awlen_q;
endmodule

// File: tb/tb_axi_aw_arb3.sv
// Directed and randomized bench for axi_aw_arb3 against a port-level arbitration model.
module tb_axi_aw_arb3;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 8;

  logic              aclk = 1'b0;
  logic              areset;
  logic              en;
  logic [1:0]        mode;
  logic [15:0]       w [3];
  logic [2:0]        vld;
  logic [ADDR_W-1:0] addr_in [3];
  logic [ID_W-1:0]   id_in [3];
  logic [LEN_W-1:0]  len_in [3];
  logic              mready;
  wire               rdy0, rdy1, rdy2;
  wire               mvalid;
  wire [ADDR_W-1:0]  maddr;
  wire [ID_W+1:0]    mid;
  wire [LEN_W-1:0]   mlen;
  wire [2:0]         rdy = {rdy2, rdy1, rdy0};

  int checks = 0;
  int failures = 0;

  // Reference model state: last accepted port, run length, and slot contents.
  int                m_last;
  int                m_cnt;
  bit                m_vld;
  logic [ADDR_W-1:0] m_addr;
  logic [ID_W+1:0]   m_id;
  logic [LEN_W-1:0]  m_len;
  int                acc_q [$];
  int                exp_q [$];

  axi_aw_arb3 #(.ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .aclk(aclk), .areset(areset), .arb_en(en), .arb_mode(mode),
    .weight_setting0(w[0]), .weight_setting1(w[1]), .weight_setting2(w[2]),
    .s0_awvalid(vld[0]), .s0_awready(rdy0), .s0_awaddr(addr_in[0]), .s0_awid(id_in[0]), .s0_awlen(len_in[0]),
    .s1_awvalid(vld[1]), .s1_awready(rdy1), .s1_awaddr(addr_in[1]), .s1_awid(id_in[1]), .s1_awlen(len_in[1]),
    .s2_awvalid(vld[2]), .s2_awready(rdy2), .s2_awaddr(addr_in[2]), .s2_awid(id_in[2]), .s2_awlen(len_in[2]),
    .m_awvalid(mvalid), .m_awready(mready), .m_awaddr(maddr), .m_awid(mid), .m_awlen(mlen)
  );

  always #5 aclk = ~aclk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_last = 2; m_cnt = 0; m_vld = 1'b0;
    m_addr = '0; m_id = '0; m_len = '0;
  endfunction

  // Which port the rules say is accepted this cycle, or -1.
  function automatic int model_grant();
    int c;
    if (areset) return -1;
    if (m_vld && !mready) return -1;
    if (!en) return vld[0] ? 0 : -1;
    if (mode == 2'd0) begin
      for (int p = 0; p < 3; p++) if (vld[p]) return p;
      return -1;
    end
    if (mode == 2'd2 && vld[m_last] && m_cnt >= 1 && m_cnt <= int'(w[m_last])) return m_last;
    for (int k = 1; k <= 3; k++) begin
      c = (m_last + k) % 3;
      if (vld[c]) return c;
    end
    return -1;
  endfunction

  task automatic rand_payload();
    for (int p = 0; p < 3; p++) begin
      addr_in[p] = $urandom;
      id_in[p]   = ID_W'($urandom);
      len_in[p]  = LEN_W'($urandom);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    int g;
    logic [2:0] er;
    @(negedge aclk);
    g  = model_grant();
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    chk("awready", 64'(rdy), 64'(er));
    chk("ready_onehot", 64'($onehot0(rdy)), 64'(1));
    chk("m_awvalid", 64'(mvalid), 64'(m_vld));
    if (m_vld) chk("m_payload", {18'd0, maddr, mid, mlen}, {18'd0, m_addr, m_id, m_len});
    @(posedge aclk);
    if (areset) begin
      model_reset();
    end else begin
      if (mready) m_vld = 1'b0;
      if (g >= 0) begin
        m_vld  = 1'b1;
        m_addr = addr_in[g];
        m_id   = {2'(g), id_in[g]};
        m_len  = len_in[g];
        acc_q.push_back(g);
        if (g == m_last) begin
          if (m_cnt < 131071) m_cnt++;
        end else begin
          m_last = g;
          m_cnt  = 1;
        end
      end
    end
    #1;
    rand_payload();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    cycle();
    cycle();
    areset = 1'b0;
    acc_q.delete();
  endtask

  task automatic chk_order(string tag);
    chk({tag, "_count"}, 64'(acc_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) chk(tag, 64'(acc_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    areset = 1'b1; en = 1'b1; mode = 2'd0; vld = 3'b000; mready = 1'b1;
    w[0] = 16'd0; w[1] = 16'd0; w[2] = 16'd0;
    rand_payload();
    @(posedge aclk);
    model_reset();
    #1;

    // Fixed priority with all ports requesting.
    do_reset();
    en = 1'b1; mode = 2'd0; vld = 3'b111; mready = 1'b1;
    repeat (6) cycle();
    exp_q = '{0, 0, 0, 0, 0, 0};
    chk_order("fixed_order");

    // Round robin from reset.
    do_reset();
    mode = 2'd1;
    repeat (6) cycle();
    exp_q = '{0, 1, 2, 0, 1, 2};
    chk_order("rr_order");

    // Weighted: W0=2, W1=0, W2=1.
    do_reset();
    mode = 2'd2; w[0] = 16'd2; w[1] = 16'd0; w[2] = 16'd1;
    repeat (9) cycle();
    exp_q = '{0, 0, 0, 1, 2, 2, 0, 0, 0};
    chk_order("wrr_order");

    // Arbitration disabled, then master back-pressure for three cycles.
    do_reset();
    en = 1'b0; mode = 2'd1;
    repeat (3) cycle();
    mready = 1'b0;
    repeat (3) cycle();
    mready = 1'b1;
    cycle();
    exp_q = '{0, 0, 0, 0};
    chk_order("noarb_order");

    // Reset while the slot is stalled, then round robin restarts at port 0.
    do_reset();
    en = 1'b1; mode = 2'd1; mready = 1'b0;
    cycle();
    cycle();
    chk("stalled_valid", 64'(mvalid), 64'(1));
    areset = 1'b1;
    cycle();
    areset = 1'b0;
    acc_q.delete();
    mready = 1'b1;
    repeat (3) cycle();
    exp_q = '{0, 1, 2};
    chk_order("post_reset_rr");

    // Randomized traffic with live configuration changes.
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        mode = 2'($urandom);
        en   = ($urandom % 6) != 0;
        for (int p = 0; p < 3; p++) w[p] = 16'($urandom % 4);
      end
      vld    = 3'($urandom);
      mready = ($urandom % 4) != 0;
      areset = ($urandom % 400) == 0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
